// File: rtl/bip_debug_sequencer.sv
// rtl/bip_debug_sequencer.sv - UART-driven load/run/step sequencer for the BIP CPU.
// Optional BIP_CYCLE_COUNT_EN appends a 16-bit valid-cycle count to the report frame.
module bip_debug_sequencer #(
  parameter int NB_DATA            = 16,
  parameter int LOG2_N_INSMEM_ADDR = 11,
  parameter int N_INSMEM_ADDR      = 2048,
  parameter int NB_BYTE            = 8
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NB_BYTE-1:0]            i_rx_data,
  input  logic                          i_rx_valid,
  output logic [NB_BYTE-1:0]            o_tx_data,
  output logic                          o_tx_start,
  input  logic                          i_tx_done,
  output logic                          o_imem_wr_en,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_imem_addr,
  output logic [NB_DATA-1:0]            o_imem_wr_data,
  output logic                          o_cpu_valid,
  output logic                          o_cpu_reset,
  input  logic                          i_cpu_halt,
  input  logic [LOG2_N_INSMEM_ADDR-1:0] i_pc,
  input  logic [NB_DATA-1:0]            i_acc
);

`ifdef BIP_CYCLE_COUNT_EN
  localparam int N_FRAME_BYTES = 6;
`else
  localparam int N_FRAME_BYTES = 4;
`endif
  localparam int NB_FRAME = N_FRAME_BYTES * NB_BYTE;

  localparam logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C;
  localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h52;
  localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h53;
  localparam logic [NB_BYTE-1:0] ACK_BYTE = 8'h4B;
  localparam logic [LOG2_N_INSMEM_ADDR-1:0] ADDR_LAST = LOG2_N_INSMEM_ADDR'(N_INSMEM_ADDR - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD_HI, LOAD_LO, LOAD_WR, CPU_RST, RUN, STEP, TX_SEND, TX_WAIT
  } state_t;

  state_t                        state_q, state_d;
  logic [LOG2_N_INSMEM_ADDR-1:0] addr_q, addr_d;
  logic [NB_DATA-1:0]            word_q, word_d;
  logic [NB_FRAME-1:0]           shift_q, shift_d;
  logic [2:0]                    tx_left_q, tx_left_d;
  logic                          cpu_rst_q, cpu_rst_d;
  logic                          step_done_q, step_done_d;
  logic                          cpu_valid;
  logic [NB_FRAME-1:0]           report;

`ifdef BIP_CYCLE_COUNT_EN
  logic [15:0] cycle_q, cycle_d;

  assign report = {{(NB_DATA-LOG2_N_INSMEM_ADDR){1'b0}}, i_pc, i_acc, cycle_q};

  always_comb begin
    cycle_d = cycle_q;
    if (state_q == CPU_RST || (state_q == IDLE && i_rx_valid && i_rx_data == CMD_STEP)) begin
      cycle_d = '0;
    end else if (cpu_valid && cycle_q != 16'hFFFF) begin
      cycle_d = cycle_q + 16'd1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) cycle_q <= '0;
    else         cycle_q <= cycle_d;
  end
`else
  assign report = {{(NB_DATA-LOG2_N_INSMEM_ADDR){1'b0}}, i_pc, i_acc};
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    word_d      = word_q;
    shift_d     = shift_q;
    tx_left_d   = tx_left_q;
    cpu_rst_d   = cpu_rst_q;
    step_done_d = 1'b0;
    cpu_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_d   = LOAD_HI;
              cpu_rst_d = 1'b1;
              addr_d    = '0;
            end
            CMD_RUN: begin
              state_d   = CPU_RST;
              cpu_rst_d = 1'b1;
            end
            CMD_STEP: state_d = STEP;
            default:  state_d = IDLE;
          endcase
        end
      end
      LOAD_HI: begin
        if (i_rx_valid) begin
          word_d  = {i_rx_data, word_q[7:0]};
          state_d = LOAD_LO;
        end
      end
      LOAD_LO: begin
        if (i_rx_valid) begin
          word_d  = {word_q[15:8], i_rx_data};
          state_d = LOAD_WR;
        end
      end
      LOAD_WR: begin
        if (word_q == '0 || addr_q == ADDR_LAST) begin
          shift_d   = {ACK_BYTE, {(NB_FRAME-NB_BYTE){1'b0}}};
          tx_left_d = 3'd1;
          state_d   = TX_SEND;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = LOAD_HI;
        end
      end
      CPU_RST: begin
        cpu_rst_d = 1'b0;
        state_d   = RUN;
      end
      RUN: begin
        if (i_cpu_halt) begin
          shift_d   = report;
          tx_left_d = 3'(N_FRAME_BYTES);
          state_d   = TX_SEND;
        end else begin
          cpu_valid = 1'b1;
        end
      end
      // Second STEP cycle samples PC/ACC after the CPU has advanced.
      STEP: begin
        if (!step_done_q) begin
          cpu_valid   = 1'b1;
          step_done_d = 1'b1;
        end else begin
          shift_d   = report;
          tx_left_d = 3'(N_FRAME_BYTES);
          state_d   = TX_SEND;
        end
      end
      TX_SEND: state_d = TX_WAIT;
      TX_WAIT: begin
        if (i_tx_done) begin
          shift_d   = shift_q << NB_BYTE;
          tx_left_d = tx_left_q - 3'd1;
          state_d   = (tx_left_q == 3'd1) ? IDLE : TX_SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      word_q      <= '0;
      shift_q     <= '0;
      tx_left_q   <= '0;
      cpu_rst_q   <= 1'b1;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      shift_q     <= shift_d;
      tx_left_q   <= tx_left_d;
      cpu_rst_q   <= cpu_rst_d;
      step_done_q <= step_done_d;
    end
  end

  assign o_tx_data      = shift_q[NB_FRAME-1 -: NB_BYTE];
  assign o_tx_start     = (state_q == TX_SEND);
  assign o_imem_wr_en   = (state_q == LOAD_WR);
  assign o_imem_addr    = addr_q;
  assign o_imem_wr_data = word_q;
  assign o_cpu_valid    = cpu_valid;
  assign o_cpu_reset    = cpu_rst_q;

endmodule

// File: tb/tb_bip_debug_sequencer.sv
// tb/tb_bip_debug_sequencer.sv - self-checking bench for bip_debug_sequencer with a toy CPU model.
// Honours BIP_CYCLE_COUNT_EN for the report frame length.
module tb_bip_debug_sequencer;

`ifdef BIP_CYCLE_COUNT_EN
  localparam int N_REPORT = 6;
`else
  localparam int N_REPORT = 4;
`endif

  logic        clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done;
  logic        o_imem_wr_en;
  logic [10:0] o_imem_addr;
  logic [15:0] o_imem_wr_data;
  logic        o_cpu_valid;
  logic        o_cpu_reset;
  logic        i_cpu_halt;
  logic [10:0] i_pc;
  logic [15:0] i_acc;

  always #5 clk = ~clk;

  bip_debug_sequencer dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_imem_wr_en(o_imem_wr_en), .o_imem_addr(o_imem_addr), .o_imem_wr_data(o_imem_wr_data),
    .o_cpu_valid(o_cpu_valid), .o_cpu_reset(o_cpu_reset),
    .i_cpu_halt(i_cpu_halt), .i_pc(i_pc), .i_acc(i_acc)
  );

  // Toy CPU: opcode [15:11]==0 is HALT; otherwise ACC += operand [10:0], PC += 1.
  logic [15:0] cpu_mem [0:2047];
  logic [10:0] cpu_pc;
  logic [15:0] cpu_acc;
  logic        preset_req;
  logic [10:0] preset_pc;
  logic [15:0] preset_acc, preset_word;

  assign i_cpu_halt = (cpu_mem[cpu_pc][15:11] == 5'd0);
  assign i_pc       = cpu_pc;
  assign i_acc      = cpu_acc;

  always @(posedge clk) begin
    if (o_imem_wr_en) cpu_mem[o_imem_addr] <= o_imem_wr_data;
    if (preset_req) begin
      cpu_pc  <= preset_pc;
      cpu_acc <= preset_acc;
      cpu_mem[preset_pc] <= preset_word;
    end else if (o_cpu_reset) begin
      cpu_pc  <= '0;
      cpu_acc <= '0;
    end else if (o_cpu_valid && !i_cpu_halt) begin
      cpu_acc <= cpu_acc + {5'd0, cpu_mem[cpu_pc][10:0]};
      cpu_pc  <= cpu_pc + 11'd1;
    end
  end

  int tx_delay = 0;
  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      i_tx_done = 1'b0;
      if (tx_delay > 0) begin
        tx_delay--;
        if (tx_delay == 0) i_tx_done = 1'b1;
      end else if (o_tx_start) begin
        tx_delay = $urandom_range(1, 4);
      end
    end
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [26:0] wr_q [$];
  logic [7:0]  tx_q [$];
  int          valid_cnt;

  task automatic tick();
    @(negedge clk);
    if (o_imem_wr_en) wr_q.push_back({o_imem_addr, o_imem_wr_data});
    if (o_tx_start)   tx_q.push_back(o_tx_data);
    if (o_cpu_valid)  valid_cnt++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wr_q.delete();
    tx_q.delete();
    valid_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    tick();
  endtask

  task automatic wait_tx(input string name, input int n);
    for (int c = 0; c < 3000 && tx_q.size() < n; c++) tick();
    repeat (12) tick();
    chk({name, "_nbytes"}, tx_q.size(), n);
  endtask

  task automatic check_report(input string name, input logic [10:0] pc,
                              input logic [15:0] acc, input logic [15:0] cnt);
    logic [47:0] f;
    f = {5'd0, pc, acc, cnt};
    wait_tx(name, N_REPORT);
    for (int i = 0; i < N_REPORT && i < tx_q.size(); i++)
      chk($sformatf("%s_b%0d", name, i), tx_q[i], f[47-8*i -: 8]);
  endtask

  task automatic load_prog(input string name, input logic [15:0] words [$]);
    clear_mon();
    send_byte(8'h4C);
    foreach (words[i]) begin
      send_byte(words[i][15:8]);
      send_byte(words[i][7:0]);
    end
    wait_tx({name, "_ack"}, 1);
    chk({name, "_nwr"}, wr_q.size(), words.size());
    for (int i = 0; i < words.size() && i < wr_q.size(); i++)
      chk($sformatf("%s_wr%0d", name, i), wr_q[i], {11'(i), words[i]});
    if (tx_q.size() > 0) chk({name, "_ackbyte"}, tx_q[0], 8'h4B);
  endtask

  task automatic run_prog(input string name, input int n_valid,
                          input logic [10:0] pc, input logic [15:0] acc);
    clear_mon();
    send_byte(8'h52);
    check_report(name, pc, acc, 16'(n_valid));
    chk({name, "_valid"}, valid_cnt, n_valid);
  endtask

  task automatic do_preset(input logic [10:0] pc, input logic [15:0] acc, input logic [15:0] w);
    preset_pc   = pc;
    preset_acc  = acc;
    preset_word = w;
    preset_req  = 1'b1;
    tick();
    preset_req  = 1'b0;
  endtask

  typedef struct {
    logic [10:0] pc0;
    logic [15:0] acc0;
    logic [15:0] instr;
    logic [10:0] pc1;
    logic [15:0] acc1;
  } step_vec_t;

  step_vec_t   steps [4];
  logic [15:0] prog [$];
  logic [15:0] w, acc_exp;
  logic [7:0]  junk;
  int          len;

  initial begin
    steps[0] = '{11'd4,     16'h1200, 16'h0834, 11'd5,     16'h1234};
    steps[1] = '{11'h7FE,   16'hFFFF, 16'hF801, 11'h7FF,   16'h0000};
    steps[2] = '{11'd9,     16'h0042, 16'h0000, 11'd9,     16'h0042};
    steps[3] = '{11'h100,   16'h8000, 16'h07FF, 11'h100,   16'h8000};

    i_reset = 1'b1; i_rx_data = '0; i_rx_valid = 1'b0; preset_req = 1'b0;
    preset_pc = '0; preset_acc = '0; preset_word = '0;
    clear_mon();
    repeat (3) tick();
    i_reset = 1'b0;
    repeat (10) tick();
    chk("rst_cpu_reset", o_cpu_reset, 1);
    chk("rst_tx_data", o_tx_data, 0);
    chk("rst_addr", o_imem_addr, 0);
    chk("rst_wr_data", o_imem_wr_data, 0);
    chk("rst_no_activity", tx_q.size() + wr_q.size() + valid_cnt, 0);

    // Step while the CPU is still held in reset.
    clear_mon();
    send_byte(8'h53);
    check_report("step_in_reset", 11'd0, 16'h0000, 16'd1);
    chk("step_in_reset_valid", valid_cnt, 1);
    chk("step_in_reset_rst", o_cpu_reset, 1);

    prog = '{16'h1805, 16'h2803, 16'h0000};
    load_prog("load_basic", prog);
    run_prog("run_basic", 2, 11'd2, 16'h0008);

    foreach (steps[k]) begin
      do_preset(steps[k].pc0, steps[k].acc0, steps[k].instr);
      clear_mon();
      send_byte(8'h53);
      if (k == 0) begin
        send_byte(8'h52);
        send_byte(8'h4C);
      end
      check_report($sformatf("step%0d", k), steps[k].pc1, steps[k].acc1, 16'd1);
      chk($sformatf("step%0d_valid", k), valid_cnt, 1);
      chk($sformatf("step%0d_rst", k), o_cpu_reset, 0);
    end

    for (int it = 0; it < 6; it++) begin
      clear_mon();
      do junk = 8'($urandom_range(0, 255));
      while (junk == 8'h4C || junk == 8'h52 || junk == 8'h53);
      send_byte(junk);
      repeat (6) tick();
      chk($sformatf("rnd%0d_junk", it), tx_q.size() + wr_q.size() + valid_cnt, 0);
      len = (it == 0) ? 4 : $urandom_range(1, 8);
      prog.delete();
      acc_exp = '0;
      for (int i = 0; i < len - 1; i++) begin
        w = {5'($urandom_range(1, 31)), 11'($urandom)};
        acc_exp = acc_exp + {5'd0, w[10:0]};
        prog.push_back(w);
      end
      prog.push_back(16'h0000);
      load_prog($sformatf("rnd%0d_load", it), prog);
      run_prog($sformatf("rnd%0d_run", it), len - 1, 11'(len - 1), acc_exp);
    end

    // Reset in the middle of a long run.
    prog.delete();
    for (int i = 0; i < 19; i++) prog.push_back(16'h0801);
    prog.push_back(16'h0000);
    load_prog("mid_load", prog);
    clear_mon();
    send_byte(8'h52);
    repeat (3) tick();
    chk("mid_running", o_cpu_valid, 1);
    i_reset = 1'b1;
    tick();
    chk("mid_rst_valid", o_cpu_valid, 0);
    chk("mid_rst_cpu_reset", o_cpu_reset, 1);
    chk("mid_rst_tx_start", o_tx_start, 0);
    i_reset = 1'b0;
    clear_mon();
    repeat (20) tick();
    chk("mid_rst_no_tx", tx_q.size(), 0);

    // Full memory: no zero word, so the last address must end the load.
    prog.delete();
    for (int i = 0; i < 2048; i++) prog.push_back(16'(i + 1));
    load_prog("full", prog);
    if (wr_q.size() > 0) chk("full_last_addr", wr_q[wr_q.size()-1][26:16], 11'h7FF);
    clear_mon();
    send_byte(8'h41);
    repeat (20) tick();
    chk("full_junk_ignored", tx_q.size() + wr_q.size() + valid_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
